// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key-schedule sequencer: loads L, fills S with Pw/Qw, runs the mixer, then hands S to the cipher.
// Optional build macro RC5_L_WIPE_EN adds a WIPE_L pass that zeroes L before READY.
module rc5_key_sched_ctrl #(
    parameter int unsigned     W   = 32,
    parameter int unsigned     C   = 4,
    parameter int unsigned     T   = 26,
    parameter logic [W-1:0]    P   = 32'hB7E15163,
    parameter logic [W-1:0]    Q   = 32'h9E3779B9,
    localparam int unsigned    LAW = (C > 1) ? $clog2(C) : 1,
    localparam int unsigned    SAW = (T > 1) ? $clog2(T) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           iStart,
    input  logic           iKeyValid,
    input  logic [W-1:0]   iKeyWord,
    output logic           oKeyReady,
    output logic           oMixStart,
    input  logic           iMixDone,
    input  logic [LAW-1:0] iMixLAddr,
    input  logic [W-1:0]   iMixLData,
    input  logic           iMixLWe,
    input  logic [SAW-1:0] iMixSAddr,
    input  logic [W-1:0]   iMixSData,
    input  logic           iMixSWe,
    input  logic [SAW-1:0] iEncSAddr,
    output logic [LAW-1:0] oLAddr,
    output logic [W-1:0]   oLData,
    output logic           oLWe,
    output logic [SAW-1:0] oSAddr,
    output logic [W-1:0]   oSData,
    output logic           oSWe,
    output logic           oBusy,
    output logic           oReady
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_L = 3'd1,
        INIT_S = 3'd2,
        MIX    = 3'd3,
        FLUSH  = 3'd4,
        READY  = 3'd5
`ifdef RC5_L_WIPE_EN
        , WIPE_L = 3'd6
`endif
    } state_t;

    localparam logic [LAW-1:0] L_LAST = LAW'(C - 1);
    localparam logic [SAW-1:0] S_LAST = SAW'(T - 1);

    state_t         state_q, state_d;
    logic [LAW-1:0] idx_q, idx_d;
    logic [SAW-1:0] i_q, i_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           key_ready_q, key_ready_d;
    logic           mix_start_q, mix_start_d;
    logic           busy_q, busy_d;
    logic           ready_q, ready_d;

    logic [LAW-1:0] l_addr;
    logic [W-1:0]   l_data;
    logic           l_we;
    logic [SAW-1:0] s_addr;
    logic [W-1:0]   s_data;
    logic           s_we;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        i_d     = i_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE, READY: begin
                if (iStart) begin
                    state_d = LOAD_L;
                    idx_d   = '0;
                end
            end
            LOAD_L: begin
                if (iKeyValid) begin
                    if (idx_q == L_LAST) begin
                        state_d = INIT_S;
                        idx_d   = '0;
                        i_d     = '0;
                        acc_d   = P;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            INIT_S: begin
                acc_d = acc_q + Q;
                if (i_q == S_LAST) begin
                    state_d = MIX;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            MIX: begin
                if (iMixDone) state_d = FLUSH;
            end
            FLUSH: begin
`ifdef RC5_L_WIPE_EN
                state_d = WIPE_L;
                idx_d   = '0;
`else
                state_d = READY;
`endif
            end
`ifdef RC5_L_WIPE_EN
            WIPE_L: begin
                if (idx_q == L_LAST) begin
                    state_d = READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        key_ready_d = (state_d == LOAD_L);
        mix_start_d = (state_d == MIX) || (state_d == FLUSH);
        busy_d      = (state_d != IDLE) && (state_d != READY);
        ready_d     = (state_d == READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            i_q         <= '0;
            acc_q       <= '0;
            key_ready_q <= 1'b0;
            mix_start_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            i_q         <= i_d;
            acc_q       <= acc_d;
            key_ready_q <= key_ready_d;
            mix_start_q <= mix_start_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    // RAM port muxes: exactly one master per state, selected by the state register only.
    always_comb begin
        l_addr = '0;
        l_data = '0;
        l_we   = 1'b0;
        s_addr = '0;
        s_data = '0;
        s_we   = 1'b0;
        case (state_q)
            LOAD_L: begin
                l_addr = idx_q;
                l_data = iKeyWord;
                l_we   = iKeyValid;
            end
            INIT_S: begin
                s_addr = i_q;
                s_data = acc_q;
                s_we   = 1'b1;
            end
            MIX, FLUSH: begin
                l_addr = iMixLAddr;
                l_data = iMixLData;
                l_we   = iMixLWe;
                s_addr = iMixSAddr;
                s_data = iMixSData;
                s_we   = iMixSWe;
            end
`ifdef RC5_L_WIPE_EN
            WIPE_L: begin
                l_addr = idx_q;
                l_we   = 1'b1;
            end
`endif
            READY: begin
                s_addr = iEncSAddr;
            end
            default: ;
        endcase
    end

    assign oLAddr    = l_addr;
    assign oLData    = l_data;
    assign oLWe      = l_we;
    assign oSAddr    = s_addr;
    assign oSData    = s_data;
    assign oSWe      = s_we;
    assign oKeyReady = key_ready_q;
    assign oMixStart = mix_start_q;
    assign oBusy     = busy_q;
    assign oReady    = ready_q;

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Directed bench for rc5_key_sched_ctrl: key load, S init values, mixer handoff, re-key and async reset.
module tb_rc5_key_sched_ctrl;

    localparam logic [31:0] PW = 32'hB7E15163;
    localparam logic [31:0] QW = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iStart = 1'b0;
    logic        iKeyValid = 1'b0;
    logic [31:0] iKeyWord = '0;
    logic        oKeyReady;
    logic        oMixStart;
    logic        iMixDone = 1'b0;
    logic [1:0]  iMixLAddr = '0;
    logic [31:0] iMixLData = '0;
    logic        iMixLWe = 1'b0;
    logic [4:0]  iMixSAddr = '0;
    logic [31:0] iMixSData = '0;
    logic        iMixSWe = 1'b0;
    logic [4:0]  iEncSAddr = '0;
    logic [1:0]  oLAddr;
    logic [31:0] oLData;
    logic        oLWe;
    logic [4:0]  oSAddr;
    logic [31:0] oSData;
    logic        oSWe;
    logic        oBusy;
    logic        oReady;

    int vectors = 0;
    int miscompares = 0;

    rc5_key_sched_ctrl dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iKeyValid(iKeyValid), .iKeyWord(iKeyWord),
        .oKeyReady(oKeyReady), .oMixStart(oMixStart), .iMixDone(iMixDone),
        .iMixLAddr(iMixLAddr), .iMixLData(iMixLData), .iMixLWe(iMixLWe),
        .iMixSAddr(iMixSAddr), .iMixSData(iMixSData), .iMixSWe(iMixSWe),
        .iEncSAddr(iEncSAddr), .oLAddr(oLAddr), .oLData(oLData), .oLWe(oLWe),
        .oSAddr(oSAddr), .oSData(oSData), .oSWe(oSWe), .oBusy(oBusy), .oReady(oReady)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic load_key(input int gap, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                iKeyValid = 1'b0;
                #1;
                chk1("lwe_idle", oLWe, 1'b0);
                chk1("key_ready", oKeyReady, 1'b1);
                tick();
            end
            iKeyValid = 1'b1;
            iKeyWord  = base + 32'(k);
            #1;
            chk1("lwe", oLWe, 1'b1);
            chkw("laddr", 32'(oLAddr), 32'(k));
            chkw("ldata", oLData, base + 32'(k));
            chk1("busy_load", oBusy, 1'b1);
            tick();
        end
        iKeyValid = 1'b0;
    endtask

    task automatic init_s(input bit start_glitch);
        logic [31:0] m;
        m = PW;
        for (int k = 0; k < 26; k++) begin
            iStart = (start_glitch && k == 5);
            #1;
            chk1("swe_init", oSWe, 1'b1);
            chkw("saddr_init", 32'(oSAddr), 32'(k));
            chkw("sdata_init", oSData, m);
            chk1("lwe_init", oLWe, 1'b0);
            if (k == 0)  chkw("s0_const", oSData, 32'hB7E15163);
            if (k == 1)  chkw("s1_const", oSData, 32'h5618CB1C);
            if (k == 2)  chkw("s2_const", oSData, 32'hF45044D5);
            if (k == 25) chkw("s25_const", oSData, 32'h2B4C3474);
            m = m + QW;
            tick();
        end
        iStart = 1'b0;
        #1;
        chk1("mix_start", oMixStart, 1'b1);
        chk1("key_ready_mix", oKeyReady, 1'b0);
        chk1("busy_mix", oBusy, 1'b1);
    endtask

    task automatic mix_finish();
        iMixSWe = 1'b1; iMixSAddr = 5'd3; iMixSData = 32'hA5A50003;
        iMixLWe = 1'b1; iMixLAddr = 2'd2; iMixLData = 32'h00005A5A;
        #1;
        chk1("mix_swe", oSWe, 1'b1);
        chkw("mix_saddr", 32'(oSAddr), 32'd3);
        chkw("mix_sdata", oSData, 32'hA5A50003);
        chk1("mix_lwe", oLWe, 1'b1);
        chkw("mix_laddr", 32'(oLAddr), 32'd2);
        chkw("mix_ldata", oLData, 32'h00005A5A);
        tick();
        iMixLWe = 1'b0;
        iMixDone = 1'b1; iMixSWe = 1'b1; iMixSAddr = 5'd7; iMixSData = 32'hDEADBEEF;
        #1;
        chkw("done_saddr", 32'(oSAddr), 32'd7);
        chk1("done_mixstart", oMixStart, 1'b1);
        tick();
        #1;
        chk1("flush_swe", oSWe, 1'b1);
        chkw("flush_saddr", 32'(oSAddr), 32'd7);
        chkw("flush_sdata", oSData, 32'hDEADBEEF);
        chk1("flush_mixstart", oMixStart, 1'b1);
        chk1("flush_ready", oReady, 1'b0);
        tick();
        iMixDone = 1'b0;
        iEncSAddr = 5'd13;
`ifdef RC5_L_WIPE_EN
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("wipe_lwe", oLWe, 1'b1);
            chkw("wipe_laddr", 32'(oLAddr), 32'(k));
            chkw("wipe_ldata", oLData, 32'd0);
            chk1("wipe_ready", oReady, 1'b0);
            chk1("wipe_mixstart", oMixStart, 1'b0);
            chk1("wipe_swe", oSWe, 1'b0);
            tick();
        end
`endif
        #1;
        chk1("ready", oReady, 1'b1);
        chk1("ready_busy", oBusy, 1'b0);
        chk1("ready_mixstart", oMixStart, 1'b0);
        chk1("ready_swe", oSWe, 1'b0);
        chk1("ready_lwe", oLWe, 1'b0);
        chkw("ready_saddr", 32'(oSAddr), 32'd13);
        iMixSWe = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        tick();
        chk1("rst_busy", oBusy, 1'b0);
        chk1("rst_ready", oReady, 1'b0);
        chk1("rst_keyready", oKeyReady, 1'b0);
        chk1("rst_mixstart", oMixStart, 1'b0);
        chk1("rst_lwe", oLWe, 1'b0);
        chk1("rst_swe", oSWe, 1'b0);
        rst = 1'b1;
        tick();
        chk1("idle_busy", oBusy, 1'b0);

        // Zero key, back-to-back words
        pulse_start();
        load_key(0, 32'd0);
        init_s(1'b0);
        mix_finish();

        // Re-key from READY with gapped key words and a stray iStart during INIT_S
        pulse_start();
        #1;
        chk1("rekey_ready", oReady, 1'b0);
        chk1("rekey_keyready", oKeyReady, 1'b1);
        chk1("rekey_busy", oBusy, 1'b1);
        load_key(2, 32'h11110000);
        init_s(1'b1);

        // Asynchronous reset in the middle of MIX
        iMixSWe = 1'b1; iMixSAddr = 5'd9; iMixLWe = 1'b1; iMixLAddr = 2'd1;
        #1;
        chk1("premrst_swe", oSWe, 1'b1);
        rst = 1'b0;
        #1;
        chk1("arst_mixstart", oMixStart, 1'b0);
        chk1("arst_busy", oBusy, 1'b0);
        chk1("arst_swe", oSWe, 1'b0);
        chk1("arst_lwe", oLWe, 1'b0);
        chk1("arst_ready", oReady, 1'b0);
        tick();
        iMixSWe = 1'b0; iMixLWe = 1'b0;
        rst = 1'b1;
        tick();
        chk1("post_rst_busy", oBusy, 1'b0);
        chk1("post_rst_ready", oReady, 1'b0);

        // Full replay after reset
        pulse_start();
        load_key(0, 32'hCAFE0000);
        init_s(1'b0);
        mix_finish();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
